// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer and the code that builds programs for it.
// Latency: none (types and constants only).
// Backpressure: none.
package prog_sequencer_pkg;

    // Processor opcodes carried in instruction bits [15:13]
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Instruction word layout: op=[15:13], imm flag=[12], rX=[11:9], immediate/rY in [8:0]
    typedef struct packed {
        logic [2:0] op;
        logic       imm;
        logic [2:0] rx;
        logic [8:0] arg;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/seq_prog_ram.sv
// Program store: DEPTH x DATA_W words, synchronous write, registered read.
// Latency: read data appears one clock after rd_vld; a same-edge write to the read address is forwarded.
// Backpressure: none; rd_dat holds its value while rd_vld is low.
module seq_prog_ram
    import prog_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage array: no reset, contents survive a sequencer reset
    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read register: write-first so a word loaded on the start edge is the one issued
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_dat <= '0;
        end else if (rd_vld) begin
            rd_dat <= (wr_vld && (wr_addr == rd_addr)) ? wr_dat : mem[rd_addr];
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Feeds a program from RAM to the multicycle processor one instruction at a time (Din + run pulse, wait done).
// Latency: first run pulse one cycle after start; next run two cycles after each done.
// Backpressure: each instruction waits for done up to a TIMEOUT-cycle watchdog; loads only accepted while idle.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [DATA_W-1:0] Din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W:0]   icount
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W:0]   len, len_nxt, icount_nxt;
    logic              finished_nxt, error_nxt;
    logic [WD_W-1:0]   wdog;

    // run is a pure state decode so it drops the instant reset asserts
    assign run  = (state == ST_ISSUE);
    assign busy = (state != ST_IDLE);

    // The RAM is read on the edge entering ISSUE, using the pc that ISSUE will show
    seq_prog_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .core_clk (clock),
        .arst_n   (reset),
        .wr_vld   (load_en && (state == ST_IDLE)),
        .wr_addr  (load_addr),
        .wr_dat   (load_data),
        .rd_vld   (state_nxt == ST_ISSUE),
        .rd_addr  (pc_nxt),
        .rd_dat   (Din)
    );

    // Next-state and next-value logic for the sequencer
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        len_nxt      = len;
        icount_nxt   = icount;
        finished_nxt = finished;
        error_nxt    = error;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    len_nxt    = (prog_len > DEPTH_C) ? DEPTH_C : prog_len;
                    pc_nxt     = '0;
                    icount_nxt = '0;
                    error_nxt  = 1'b0;
                    if (len_nxt == '0) begin
                        finished_nxt = 1'b1;
                        state_nxt    = ST_HALT;
                    end else begin
                        finished_nxt = 1'b0;
                        state_nxt    = ST_ISSUE;
                    end
                end else begin
                    // HALT lasts one cycle so the loader is reopened promptly
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // done wins over watchdog expiry in the same cycle
                if (done) begin
                    icount_nxt = (icount == DEPTH_C) ? icount : icount + 1'b1;
                    state_nxt  = ST_ADVANCE;
                end else if (wdog == WD_LAST) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_ADVANCE: begin
                if (icount == len) begin
                    finished_nxt = 1'b1;
                    state_nxt    = ST_HALT;
                end else begin
                    pc_nxt    = pc + 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and status registers; the watchdog counts from the run pulse and is cleared elsewhere
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            len      <= '0;
            icount   <= '0;
            finished <= 1'b0;
            error    <= 1'b0;
            wdog     <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            len      <= len_nxt;
            icount   <= icount_nxt;
            finished <= finished_nxt;
            error    <= error_nxt;
            wdog     <= ((state == ST_ISSUE) || (state == ST_WAIT)) ? wdog + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;
    import prog_sequencer_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 32;
    localparam int NEVER   = 999;
    localparam int MAXC    = 1024;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              done;
    logic [DATA_W-1:0] Din;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              finished;
    logic              error;
    logic [ADDR_W:0]   icount;

    always #5 clock = ~clock;

    prog_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .done      (done),
        .Din       (Din),
        .run       (run),
        .pc        (pc),
        .busy      (busy),
        .finished  (finished),
        .error     (error),
        .icount    (icount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    logic [DATA_W-1:0] mram [DEPTH];
    int                lat_plan [64];
    logic [DATA_W-1:0] m_din;
    int                m_pc, m_icnt;
    logic              m_fin, m_err, m_busy;
    int                junk_pct = 25;

    // Expected per-cycle timeline of one run, cycle 0 = the start cycle
    logic              e_run [MAXC], e_busy [MAXC], e_fin [MAXC], e_err [MAXC], e_done [MAXC];
    logic [DATA_W-1:0] e_din [MAXC];
    int                e_pc [MAXC], e_icnt [MAXC];

    logic [DATA_W-1:0] cur_din;
    int                cur_pc, cur_icnt;
    logic              cur_run, cur_busy, cur_fin, cur_err;

    int chk_k;
    bit chk_en = 1'b0;
    int runs_seen = 0;
    logic [15:0] r [8];

    task automatic put(input int c, input bit d);
        e_run[c]  = cur_run;
        e_busy[c] = cur_busy;
        e_fin[c]  = cur_fin;
        e_err[c]  = cur_err;
        e_din[c]  = cur_din;
        e_pc[c]   = cur_pc;
        e_icnt[c] = cur_icnt;
        e_done[c] = d;
    endtask

    // Minimal instruction executor standing in for the processor
    task automatic exec(input logic [15:0] w);
        instr_t      iw;
        logic [15:0] opnd;
        iw   = instr_t'(w);
        opnd = iw.imm ? {7'd0, iw.arg} : r[iw.arg[2:0]];
        case (iw.op)
            OP_MV:   r[iw.rx] = opnd;
            OP_MVT:  r[iw.rx] = {iw.arg[7:0], 8'h00};
            OP_ADD:  r[iw.rx] = r[iw.rx] + opnd;
            OP_SUB:  r[iw.rx] = r[iw.rx] - opnd;
            default: ;
        endcase
    endtask

    always @(negedge clock) begin
        if (run === 1'b1) begin
            runs_seen++;
            exec(Din);
        end
    end

    // Single compare process: DUT outputs against the model timeline
    always @(negedge clock) begin
        if (chk_en) begin
            check("run",      chk_k, 32'(run),      32'(e_run[chk_k]));
            check("busy",     chk_k, 32'(busy),     32'(e_busy[chk_k]));
            check("finished", chk_k, 32'(finished), 32'(e_fin[chk_k]));
            check("error",    chk_k, 32'(error),    32'(e_err[chk_k]));
            check("pc",       chk_k, 32'(pc),       e_pc[chk_k]);
            check("icount",   chk_k, 32'(icount),   e_icnt[chk_k]);
            check("Din",      chk_k, 32'(Din),      32'(e_din[chk_k]));
        end
    end

    task automatic load_word(input int a, input logic [DATA_W-1:0] w);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = w;
        mram[a]   = w;
        @(posedge clock); #1;
        load_en   = 1'b0;
    endtask

    // Build the expected timeline from the program rules, then drive and compare it.
    // chain: leave the block in its HALT cycle so the next run starts from HALT.
    // ld0: load a fresh word into address 0 in the start cycle.
    task automatic do_run(input int len, input bit chain, input bit ld0);
        int elen, c, halt_c, n, idx, exp_runs;
        logic [DATA_W-1:0] w0;
        elen     = (len > DEPTH) ? DEPTH : len;
        exp_runs = 0;
        halt_c   = 1;
        w0       = DATA_W'($urandom);
        if (ld0 && !m_busy) mram[0] = w0;
        cur_din = m_din; cur_pc = m_pc; cur_icnt = m_icnt;
        cur_fin = m_fin; cur_err = m_err; cur_busy = m_busy; cur_run = 1'b0;
        put(0, 1'b0);
        cur_pc = 0; cur_icnt = 0; cur_fin = 1'b0; cur_err = 1'b0; cur_busy = 1'b1;
        c = 1;
        if (elen == 0) begin
            cur_fin = 1'b1;
            put(1, 1'b0);
            c = 2;
        end else begin
            for (int i = 0; i < elen; i++) begin
                cur_pc = i; cur_din = mram[i]; cur_run = 1'b1;
                put(c, 1'($urandom_range(0, 1)));
                exp_runs++;
                c++;
                cur_run = 1'b0;
                if (lat_plan[i] < TIMEOUT) begin
                    for (int j = 1; j <= lat_plan[i]; j++) begin
                        put(c, j == lat_plan[i]);
                        c++;
                    end
                    cur_icnt++;
                    put(c, 1'b0);
                    c++;
                    if (i == elen - 1) begin
                        cur_fin = 1'b1;
                        halt_c  = c;
                        put(c, 1'b0);
                        c++;
                    end
                end else begin
                    for (int j = 1; j < TIMEOUT; j++) begin
                        put(c, 1'b0);
                        c++;
                    end
                    cur_err = 1'b1;
                    halt_c  = c;
                    put(c, 1'b0);
                    c++;
                    break;
                end
            end
        end
        cur_busy = 1'b0;
        put(c, 1'b0);
        put(c + 1, 1'b0);
        n = chain ? halt_c : c + 2;

        runs_seen = 0;
        for (int k = 0; k < n; k++) begin
            start     = (k == 0);
            prog_len  = (k == 0) ? (ADDR_W+1)'(len) : (ADDR_W+1)'($urandom);
            done      = e_done[k];
            load_en   = 1'b0;
            load_addr = ADDR_W'(k % 4);
            load_data = DATA_W'($urandom);
            if (k == 0 && ld0) begin
                load_en   = 1'b1;
                load_addr = '0;
                load_data = w0;
            end else if (e_busy[k] && ($urandom_range(0, 99) < junk_pct)) begin
                load_en = 1'b1;
            end
            chk_k  = k;
            chk_en = 1'b1;
            @(posedge clock); #1;
        end
        chk_en  = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        load_en = 1'b0;
        check("run_pulses", n, runs_seen, exp_runs);
        idx    = chain ? halt_c : c + 1;
        m_din  = e_din[idx];
        m_pc   = e_pc[idx];
        m_icnt = e_icnt[idx];
        m_fin  = e_fin[idx];
        m_err  = e_err[idx];
        m_busy = chain;
    endtask

    initial begin
        int len;
        bit chain, ld0;
        reset = 1'b0; start = 1'b0; done = 1'b0; load_en = 1'b0;
        load_addr = '0; load_data = '0; prog_len = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_run",      0, 32'(run),      32'd0);
        check("rst_busy",     0, 32'(busy),     32'd0);
        check("rst_pc",       0, 32'(pc),       32'd0);
        check("rst_icount",   0, 32'(icount),   32'd0);
        check("rst_Din",      0, 32'(Din),      32'd0);
        check("rst_finished", 0, 32'(finished), 32'd0);
        check("rst_error",    0, 32'(error),    32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        for (int a = 0; a < DEPTH; a++) load_word(a, DATA_W'($urandom));
        m_din = '0; m_pc = 0; m_icnt = 0; m_fin = 1'b0; m_err = 1'b0; m_busy = 1'b0;

        // Single instruction, done two cycles after run
        load_word(0, 16'h1002);
        lat_plan[0] = 2;
        do_run(1, 1'b0, 1'b0);
        check("t1_finished", 0, 32'(finished), 32'd1);
        check("t1_icount",   0, 32'(icount),   32'd1);
        check("t1_error",    0, 32'(error),    32'd0);
        check("t1_Din",      0, 32'(Din),      32'h1002);
        check("t1_pulses",   0, runs_seen,     1);

        // Four-instruction program through the instruction executor
        load_word(0, 16'h1002);
        load_word(1, 16'h3207);
        load_word(2, 16'h4001);
        load_word(3, 16'h7007);
        for (int i = 0; i < 8; i++) r[i] = '0;
        for (int i = 0; i < 4; i++) lat_plan[i] = $urandom_range(1, 6);
        do_run(4, 1'b0, 1'b0);
        check("t2_r0", 0, 32'(r[0]), 32'h06FB);
        check("t2_r1", 0, 32'(r[1]), 32'h0700);
        check("t2_pc", 0, 32'(pc),   32'd3);

        // Watchdog expiry on the first instruction
        lat_plan[0] = NEVER;
        lat_plan[1] = 1;
        do_run(2, 1'b0, 1'b0);
        check("t3_error",    0, 32'(error),    32'd1);
        check("t3_finished", 0, 32'(finished), 32'd0);
        check("t3_icount",   0, 32'(icount),   32'd0);
        check("t3_pc",       0, 32'(pc),       32'd0);
        check("t3_pulses",   0, runs_seen,     1);

        // done on the expiry cycle still succeeds
        lat_plan[0] = TIMEOUT - 1;
        do_run(1, 1'b0, 1'b0);
        check("t4_error",    0, 32'(error),    32'd0);
        check("t4_finished", 0, 32'(finished), 32'd1);

        // Empty program
        do_run(0, 1'b0, 1'b0);
        check("t5_finished", 0, 32'(finished), 32'd1);
        check("t5_pulses",   0, runs_seen,     0);
        check("t5_busy",     0, 32'(busy),     32'd0);

        // Relaunch straight from HALT, then start with a same-cycle load from IDLE
        do_run(0, 1'b1, 1'b0);
        lat_plan[0] = 1; lat_plan[1] = 1;
        do_run(2, 1'b0, 1'b1);
        lat_plan[0] = 3;
        do_run(1, 1'b0, 1'b1);

        // Loads while busy must be dropped
        load_word(1, 16'h5A5A);
        junk_pct = 100;
        lat_plan[0] = 3; lat_plan[1] = 3;
        do_run(2, 1'b0, 1'b0);
        junk_pct = 25;
        check("t7_Din", 0, 32'(Din), 32'h5A5A);
        check("t7_pc",  0, 32'(pc),  32'd1);

        // Reset during WAIT of the second instruction
        start = 1'b1; prog_len = 6'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("t8_pc_pre",   0, 32'(pc),     32'd1);
        check("t8_icnt_pre", 0, 32'(icount), 32'd1);
        check("t8_busy_pre", 0, 32'(busy),   32'd1);
        #2 reset = 1'b0;
        #1;
        check("t8_run",      0, 32'(run),      32'd0);
        check("t8_busy",     0, 32'(busy),     32'd0);
        check("t8_pc",       0, 32'(pc),       32'd0);
        check("t8_icount",   0, 32'(icount),   32'd0);
        check("t8_Din",      0, 32'(Din),      32'd0);
        check("t8_finished", 0, 32'(finished), 32'd0);
        check("t8_error",    0, 32'(error),    32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        m_din = '0; m_pc = 0; m_icnt = 0; m_fin = 1'b0; m_err = 1'b0; m_busy = 1'b0;
        lat_plan[0] = 2; lat_plan[1] = 2;
        do_run(2, 1'b0, 1'b0);

        // Randomized programs, latencies, lengths (including clamped ones) and chaining
        for (int it = 0; it < 30; it++) begin
            if (!m_busy) begin
                repeat ($urandom_range(0, 3)) load_word($urandom_range(0, DEPTH - 1), DATA_W'($urandom));
            end
            len = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 6) : $urandom_range(0, 63);
            for (int i = 0; i < 64; i++) begin
                lat_plan[i] = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(1, TIMEOUT - 1);
            end
            chain = ($urandom_range(0, 3) == 0);
            ld0   = 1'($urandom_range(0, 1));
            do_run(len, chain, ld0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
